// File: rtl/wb_load_writer_if.sv
// wb_load_writer_if: MEM-to-WB handshake, data-SRAM response and register-file write bus
interface wb_load_writer_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic [2:0]  ms_op;
  logic [1:0]  ms_addr_lo;
  logic [31:0] ms_result;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        ws_flush;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  ws_dest_valid;
  logic        ws_load_pending;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  modport master (
    output ms_to_ws_valid, ms_pc, ms_dest, ms_op, ms_addr_lo, ms_result, data_data_ok, data_rdata, ws_flush,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, ws_dest_valid, ws_load_pending, debug_wb_pc, debug_wb_rf_wen
  );
  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_dest, ms_op, ms_addr_lo, ms_result, data_data_ok, data_rdata, ws_flush,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, ws_dest_valid, ws_load_pending, debug_wb_pc, debug_wb_rf_wen
  );
endinterface

// File: rtl/wb_load_writer.sv
// wb_load_writer: writeback stage that aligns load data and drives byte-enabled register-file writes
module wb_load_writer #(
  parameter int DISCARD_W = 2
) (
  input logic              clk,
  input logic              resetn,
  wb_load_writer_if.slave  bus
);
  localparam logic [2:0] OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3, OP_LHU = 3'd4,
                         OP_LWL = 3'd5, OP_LWR = 3'd6, OP_ALU = 3'd7;
  logic                 ws_valid, data_buf_valid;
  logic [31:0]          ws_pc, ws_result, data_buf, d, wdata;
  logic [4:0]           ws_dest;
  logic [2:0]           ws_op;
  logic [1:0]           a;
  logic [DISCARD_W-1:0] discard_cnt;
  logic                 is_load, cnt_zero, arrive, ws_ready_go, retire, accept, cnt_inc, cnt_dec;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [3:0]           we;
  assign is_load     = ws_op != OP_ALU;
  assign cnt_zero    = discard_cnt == '0;
  assign arrive      = bus.data_data_ok && cnt_zero;
  assign ws_ready_go = !is_load || data_buf_valid || arrive;
  assign retire      = ws_valid && ws_ready_go && !bus.ws_flush;
  assign accept      = bus.ms_to_ws_valid && bus.ws_allowin && !bus.ws_flush;
  // a flushed load still owes a response unless it arrives in the flush cycle itself
  assign cnt_inc     = bus.ws_flush && ws_valid && is_load && !data_buf_valid && !arrive;
  assign cnt_dec     = bus.data_data_ok && !cnt_zero;
  assign d           = arrive ? bus.data_rdata : data_buf;
  assign byte_v      = d[{a, 3'b000} +: 8];
  assign half_v      = a[1] ? d[31:16] : d[15:0];
  always_comb begin
    we    = 4'hf;
    wdata = d;
    case (ws_op)
      OP_LB, OP_LBU: wdata = {{24{ws_op == OP_LB && byte_v[7]}}, byte_v};
      OP_LH, OP_LHU: wdata = {{16{ws_op == OP_LH && half_v[15]}}, half_v};
      OP_LWL: begin
        we    = 4'hf << ~a;
        wdata = d << {~a, 3'b000};
      end
      OP_LWR: begin
        we    = 4'hf >> a;
        wdata = d >> {a, 3'b000};
      end
      OP_ALU: wdata = ws_result;
      default: ;
    endcase
  end
  assign bus.ws_allowin      = !ws_valid || ws_ready_go;
  assign bus.rf_we           = retire && ws_dest != 5'd0 ? we : 4'h0;
  assign bus.rf_waddr        = ws_dest;
  assign bus.rf_wdata        = wdata;
  assign bus.ws_dest_valid   = ws_valid ? ws_dest : 5'd0;
  assign bus.ws_load_pending = ws_valid && is_load && !data_buf_valid && !arrive;
  assign bus.debug_wb_pc     = ws_pc;
  assign bus.debug_wb_rf_wen = bus.rf_we;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid       <= 1'b0;
      data_buf_valid <= 1'b0;
      discard_cnt    <= '0;
      data_buf       <= '0;
      ws_pc          <= '0;
      ws_result      <= '0;
      ws_dest        <= '0;
      ws_op          <= '0;
      a              <= '0;
    end else begin
      ws_valid       <= accept || (ws_valid && !retire && !bus.ws_flush);
      data_buf_valid <= !bus.ws_flush && !retire && (data_buf_valid || (arrive && ws_valid && is_load));
      if (arrive) data_buf <= bus.data_rdata;
      if (accept) begin
        ws_pc     <= bus.ms_pc;
        ws_result <= bus.ms_result;
        ws_dest   <= bus.ms_dest;
        ws_op     <= bus.ms_op;
        a         <= bus.ms_addr_lo;
      end
      if (cnt_inc && !cnt_dec && !(&discard_cnt)) discard_cnt <= discard_cnt + DISCARD_W'(1);
      else if (cnt_dec && !cnt_inc) discard_cnt <= discard_cnt - DISCARD_W'(1);
    end
  end
  a_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    bus.data_data_ok && cnt_zero |-> ws_valid && is_load);
endmodule
